mdio_poll_seq: RTL
==================

// Module: mdio_poll_seq
// PURPOSE
// Command sequencer sitting directly upstream of the MDIO master engine. After reset it
// issues one init write to the PHY control register (BMCR), then polls the status register
// (BMSR) periodically through a valid/ready command port. It consumes read responses and
// publishes link state, raw status and error flags to the top level (LEDs, management logic).
// PARAMETERS
// PHY_ADDR       5'd1        PHY address placed on every command
// INIT_DATA      16'h1200    BMCR (reg 0) init value: autoneg enable + restart
// POLL_INTERVAL  1000000     idle CLK cycles between poll completion and next poll request (>=1)
// RSP_TIMEOUT    4096        CLK cycles to wait for RSP_VALID after a command handshake (>=2)
// PORTS
// CLK         in   1   system clock; all logic on posedge
// RST         in   1   synchronous active-high reset
// ENABLE      in   1   1 = run sequence; 0 = park after any outstanding transaction
// CMD_VALID   out  1   command request to MDIO master
// CMD_READY   in   1   master accepts command (handshake = VALID & READY at posedge CLK)
// CMD_WRITE   out  1   1 = write, 0 = read
// CMD_PHY     out  5   PHY address (= PHY_ADDR)
// CMD_REG     out  5   register address (0 = init write, 1 = poll read)
// CMD_WDATA   out  16  write data (INIT_DATA for writes, 0 for reads)
// RSP_VALID   in   1   one-cycle pulse: transaction finished (reads and writes)
// RSP_RDATA   in   16  read data, valid with RSP_VALID
// INIT_DONE   out  1   init write completed (sticky until RST)
// LINK_UP     out  1   BMSR bit 2 from last successful poll
// LINK_CHG    out  1   one-cycle pulse when LINK_UP changes
// STATUS      out  16  last successfully read BMSR value
// TIMEOUT_ERR out  1   sticky: some transaction exceeded RSP_TIMEOUT; cleared only by RST
// BEHAVIOUR
// - Reset: state S_IDLE; CMD_VALID=0, CMD_WRITE=0, CMD_REG=0, CMD_WDATA=0, INIT_DONE=0,
//   LINK_UP=0, LINK_CHG=0, STATUS=0, TIMEOUT_ERR=0; timers cleared. Reset mid-transaction
//   abandons it; CMD_VALID is low after the reset edge (master is reset together).
// - States: S_IDLE, S_INIT_REQ, S_INIT_WAIT, S_POLL_REQ, S_POLL_WAIT, S_INTERVAL.
// - S_IDLE: if ENABLE, -> S_INIT_REQ when INIT_DONE=0, else -> S_POLL_REQ.
// - *_REQ: CMD_VALID=1 with fields stable until handshake; no change while READY=0. On
//   handshake -> matching *_WAIT; CMD_VALID low the next cycle; timeout counter cleared.
// - RSP_VALID outside *_WAIT is ignored; no command is ever outstanding twice.
// - S_INIT_WAIT: on RSP_VALID set INIT_DONE, -> S_POLL_REQ (first poll immediately).
// - S_POLL_WAIT: on RSP_VALID, STATUS<=RSP_RDATA and LINK_UP<=RSP_RDATA[2] on the same
//   edge. LINK_CHG=1 for exactly the following cycle if the new bit differs. -> S_INTERVAL.
// - Timeout: counter increments every cycle in *_WAIT. If RSP_TIMEOUT cycles pass without
//   RSP_VALID, set TIMEOUT_ERR and -> S_INTERVAL. STATUS, LINK_UP and INIT_DONE are
//   unchanged. A failed init is retried from S_IDLE after the interval. RSP_VALID arriving
//   in the same cycle the count expires counts as success.
// - S_INTERVAL: counts POLL_INTERVAL cycles, then -> S_IDLE (re-evaluates ENABLE).
// - ENABLE=0 never aborts *_REQ after handshake or *_WAIT. In *_REQ before handshake,
//   CMD_VALID is held; the request completes normally. ENABLE is sampled only in S_IDLE.
// - Counters are sized $clog2(param+1) and saturate, never wrap.
// TESTING (POLL_INTERVAL=16, RSP_TIMEOUT=8, PHY_ADDR=1, INIT_DATA=16'h1200)
// 1 RST then ENABLE=1, READY=1 -> write cmd PHY=1 REG=0 WDATA=1200; RSP 3 cycles later ->
//   INIT_DONE=1, read cmd REG=1 issued next.
// 2 Poll RSP_RDATA=16'h786D -> STATUS=786D, LINK_UP=1, one LINK_CHG pulse. Next poll 786D
//   -> no pulse. Then 7869 -> LINK_UP=0 plus pulse. Poll spacing >= 16 cycles.
// 3 READY held low 10 cycles -> CMD_VALID and fields stable; exactly one handshake.
// 4 No RSP after read handshake -> TIMEOUT_ERR=1 at 8 cycles, STATUS unchanged; next poll
//   follows; a stray late RSP_VALID is ignored.
// 5 ENABLE=0 during S_POLL_WAIT -> response still captured, then FSM parks in S_IDLE with no
//   CMD_VALID. ENABLE=1 -> read cmd (no re-init).
// 6 RST asserted mid-S_POLL_WAIT -> all outputs at reset values next cycle; re-init write
//   issued after release.

Source files
------------

// File: rtl/mdio_poll_seq.sv
// Sequencer ahead of the MDIO master: one BMCR init write, then periodic BMSR polls.
// Latency: command raised one cycle after leaving S_IDLE; status/link update on the response edge.
// Backpressure: CMD_VALID and fields held until CMD_READY; response wait bounded by RSP_TIMEOUT.
module mdio_poll_seq #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [15:0] INIT_DATA     = 16'h1200,
    parameter int          POLL_INTERVAL = 1000000,
    parameter int          RSP_TIMEOUT   = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic        CMD_WRITE,
    output logic [4:0]  CMD_PHY,
    output logic [4:0]  CMD_REG,
    output logic [15:0] CMD_WDATA,
    input  logic        RSP_VALID,
    input  logic [15:0] RSP_RDATA,
    output logic        INIT_DONE,
    output logic        LINK_UP,
    output logic        LINK_CHG,
    output logic [15:0] STATUS,
    output logic        TIMEOUT_ERR
);
    localparam int IW = $clog2(POLL_INTERVAL + 1);
    localparam int TW = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_REQ,
        S_INIT_WAIT,
        S_POLL_REQ,
        S_POLL_WAIT,
        S_INTERVAL
    } state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  ivl_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           in_wait;
    logic           tmo_hit;
    logic           ivl_done;

    assign in_wait  = (state == S_INIT_WAIT) || (state == S_POLL_WAIT);
    // A response in the expiry cycle wins, so tmo_hit is only acted on without RSP_VALID.
    assign tmo_hit  = in_wait && (tmo_cnt == TW'(RSP_TIMEOUT - 1));
    assign ivl_done = (ivl_cnt == IW'(POLL_INTERVAL - 1));
    assign CMD_PHY  = PHY_ADDR;

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (ENABLE) state_nxt = INIT_DONE ? S_POLL_REQ : S_INIT_REQ;
            S_INIT_REQ:  if (CMD_READY) state_nxt = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (RSP_VALID)    state_nxt = S_POLL_REQ;
                else if (tmo_hit) state_nxt = S_INTERVAL;
            end
            S_POLL_REQ:  if (CMD_READY) state_nxt = S_POLL_WAIT;
            S_POLL_WAIT: if (RSP_VALID || tmo_hit) state_nxt = S_INTERVAL;
            S_INTERVAL:  if (ivl_done) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_REG   = 5'd0;
        CMD_WDATA = 16'h0000;
        if (state == S_INIT_REQ) begin
            CMD_VALID = 1'b1;
            CMD_WRITE = 1'b1;
            CMD_WDATA = INIT_DATA;
        end else if (state == S_POLL_REQ) begin
            CMD_VALID = 1'b1;
            CMD_REG   = 5'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !in_wait)                    tmo_cnt <= '0;
        else if (tmo_cnt != TW'(RSP_TIMEOUT))   tmo_cnt <= tmo_cnt + TW'(1);
        if (RST || state != S_INTERVAL)         ivl_cnt <= '0;
        else if (ivl_cnt != IW'(POLL_INTERVAL)) ivl_cnt <= ivl_cnt + IW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            INIT_DONE   <= 1'b0;
            LINK_UP     <= 1'b0;
            LINK_CHG    <= 1'b0;
            STATUS      <= 16'h0000;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            LINK_CHG <= 1'b0;
            if (state == S_INIT_WAIT && RSP_VALID) INIT_DONE <= 1'b1;
            if (state == S_POLL_WAIT && RSP_VALID) begin
                STATUS   <= RSP_RDATA;
                LINK_UP  <= RSP_RDATA[2];
                LINK_CHG <= RSP_RDATA[2] ^ LINK_UP;
            end
            if (tmo_hit && !RSP_VALID) TIMEOUT_ERR <= 1'b1;
        end
    end
endmodule
